// File: rtl/gb_reg_file.sv
// Register bank with two byte read ports, byte/pair writes, pair inc/dec and a one-deep shadow bank.
// Optional macro GB_REGFILE_BYPASS_EN forwards the next-edge committed value to all read ports.
module gb_reg_file #(
  parameter int WID   = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WID-1:0]   wr_data,
  input  logic [1:0]       pair_op,
  input  logic [AW-2:0]    pair_addr,
  input  logic [2*WID-1:0] pair_data,
  input  logic             save,
  input  logic             restore,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WID-1:0]   rd_data_a,
  output logic [WID-1:0]   rd_data_b,
  input  logic [AW-2:0]    pair_rd_addr,
  output logic [2*WID-1:0] pair_rd_data,
  output logic             wrap,
  output logic             shadow_valid
);

  typedef enum logic [1:0] {
    PAIR_NONE = 2'b00,
    PAIR_LOAD = 2'b01,
    PAIR_INC  = 2'b10,
    PAIR_DEC  = 2'b11
  } pair_op_t;

  localparam logic [2*WID-1:0] PAIR_ONE = {{(2*WID-1){1'b0}}, 1'b1};

  logic [WID-1:0]   regs        [DEPTH];
  logic [WID-1:0]   shadow      [DEPTH];
  logic [WID-1:0]   next_regs   [DEPTH];
  logic [WID-1:0]   next_shadow [DEPTH];
  logic [WID-1:0]   view        [DEPTH];
  logic             next_valid;
  logic             next_wrap;
  logic             do_restore;
  logic [AW-1:0]    pair_hi;
  logic [AW-1:0]    pair_lo;
  logic [2*WID-1:0] pair_cur;
  logic [2*WID-1:0] pair_res;

  assign pair_hi    = {pair_addr, 1'b0};
  assign pair_lo    = {pair_addr, 1'b1};
  assign pair_cur   = {regs[pair_hi], regs[pair_lo]};
  // A restore blocked by clr leaves the shadow intact, so a concurrent save still lands.
  assign do_restore = restore & shadow_valid & ~clr;

  // Resolve every update for this edge; the pair result overwrites a colliding byte write.
  always_comb begin
    next_regs   = regs;
    next_shadow = shadow;
    next_valid  = shadow_valid;
    next_wrap   = 1'b0;
    pair_res    = pair_cur;
    if (save && !do_restore) begin
      next_shadow = regs;
      next_valid  = 1'b1;
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) next_regs[i] = '0;
    end else if (do_restore) begin
      next_regs  = shadow;
      next_valid = 1'b0;
    end else begin
      if (wr_en) next_regs[wr_addr] = wr_data;
      case (pair_op_t'(pair_op))
        PAIR_LOAD: pair_res = pair_data;
        PAIR_INC: begin
          pair_res  = pair_cur + PAIR_ONE;
          next_wrap = &pair_cur;
        end
        PAIR_DEC: begin
          pair_res  = pair_cur - PAIR_ONE;
          next_wrap = ~|pair_cur;
        end
        default: pair_res = pair_cur;
      endcase
      if (pair_op != PAIR_NONE) begin
        next_regs[pair_hi] = pair_res[2*WID-1:WID];
        next_regs[pair_lo] = pair_res[WID-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
      wrap         <= 1'b0;
      shadow_valid <= 1'b0;
    end else begin
      regs         <= next_regs;
      shadow       <= next_shadow;
      wrap         <= next_wrap;
      shadow_valid <= next_valid;
    end
  end

`ifdef GB_REGFILE_BYPASS_EN
  always_comb view = next_regs;
`else
  always_comb view = regs;
`endif

  assign rd_data_a    = view[rd_addr_a];
  assign rd_data_b    = view[rd_addr_b];
  assign pair_rd_data = {view[{pair_rd_addr, 1'b0}], view[{pair_rd_addr, 1'b1}]};

endmodule

// File: tb/tb_gb_reg_file.sv
// Self-checking bench for gb_reg_file: directed scenarios plus randomized traffic
// against an array/integer reference model of the register bank.
module tb_gb_reg_file;

  logic        clk = 1'b0;
  logic        reset, clr, wr_en, save, restore;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0]  wr_data;
  logic [1:0]  pair_op, pair_addr, pair_rd_addr;
  logic [15:0] pair_data;
  logic [7:0]  rd_data_a, rd_data_b;
  logic [15:0] pair_rd_data;
  logic        wrap, shadow_valid;

  int tests_run = 0;
  int fails = 0;

  logic [7:0] m_regs [8];
  logic [7:0] m_shadow [8];
  logic       m_valid, m_wrap;
  logic [7:0] n_regs [8];
  logic [7:0] n_shadow [8];
  logic       n_valid, n_wrap;

  gb_reg_file #(.WID(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pair_op(pair_op), .pair_addr(pair_addr),
    .pair_data(pair_data), .save(save), .restore(restore),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .pair_rd_addr(pair_rd_addr),
    .pair_rd_data(pair_rd_data), .wrap(wrap), .shadow_valid(shadow_valid)
  );

  always #5 clk = ~clk;

  // Reference: what the bank holds after the coming edge, from the operation rules.
  task automatic model_step();
    int  val;
    int  p;
    bit  rest;
    n_regs   = m_regs;
    n_shadow = m_shadow;
    n_valid  = m_valid;
    n_wrap   = 1'b0;
    rest     = restore && m_valid && !clr;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        n_regs[i]   = 8'h00;
        n_shadow[i] = 8'h00;
      end
      n_valid = 1'b0;
      return;
    end
    if (save && !rest) begin
      n_shadow = m_regs;
      n_valid  = 1'b1;
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) n_regs[i] = 8'h00;
    end else if (rest) begin
      n_regs  = m_shadow;
      n_valid = 1'b0;
    end else begin
      if (wr_en) n_regs[wr_addr] = wr_data;
      p   = int'(pair_addr);
      val = int'(m_regs[2*p]) * 256 + int'(m_regs[2*p+1]);
      if (pair_op == 2'd1) val = int'(pair_data);
      if (pair_op == 2'd2) begin
        val = val + 1;
        if (val == 65536) begin val = 0; n_wrap = 1'b1; end
      end
      if (pair_op == 2'd3) begin
        val = val - 1;
        if (val < 0) begin val = 65535; n_wrap = 1'b1; end
      end
      if (pair_op != 2'd0) begin
        n_regs[2*p]   = 8'(val / 256);
        n_regs[2*p+1] = 8'(val % 256);
      end
    end
  endtask

  function automatic logic [7:0] exp_view(input logic [2:0] a);
`ifdef GB_REGFILE_BYPASS_EN
    return n_regs[a];
`else
    return m_regs[a];
`endif
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    m_regs   = n_regs;
    m_shadow = n_shadow;
    m_valid  = n_valid;
    m_wrap   = n_wrap;
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; clr = 1'b0; wr_en = 1'b0; save = 1'b0; restore = 1'b0;
    pair_op = 2'd0; wr_addr = 3'd0; wr_data = 8'h00; pair_addr = 2'd0;
    pair_data = 16'h0000;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      tests_run++;
      if (rd_data_a !== 8'h00) begin
        fails++;
        $display("[TB] FAIL reset_rd_a[%0d]: got %h expected 00", i, rd_data_a);
      end
      tests_run++;
      if (rd_data_b !== 8'h00) begin
        fails++;
        $display("[TB] FAIL reset_rd_b[%0d]: got %h expected 00", 7 - i, rd_data_b);
      end
    end
    for (int p = 0; p < 4; p++) begin
      pair_rd_addr = 2'(p);
      #1;
      tests_run++;
      if (pair_rd_data !== 16'h0000) begin
        fails++;
        $display("[TB] FAIL reset_pair[%0d]: got %h expected 0000", p, pair_rd_data);
      end
    end
    tests_run++;
    if (wrap !== 1'b0 || shadow_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got wrap=%b valid=%b expected 0 0", wrap, shadow_valid);
    end
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick();
    idle();
    rd_addr_a = 3'd3;
    #1;
    tests_run++;
    if (rd_data_a !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL byte_write: got %h expected a5", rd_data_a);
    end
  endtask

  task automatic test_pair_inc();
    idle();
    pair_op = 2'd1; pair_addr = 2'd2; pair_data = 16'h12FF;
    tick();
    pair_op = 2'd2;
    tick();
    idle();
    pair_rd_addr = 2'd2; rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    #1;
    tests_run++;
    if (pair_rd_data !== 16'h1300 || rd_data_a !== 8'h13 || rd_data_b !== 8'h00 || wrap !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pair_inc: got %h %h %h wrap=%b expected 1300 13 00 0",
               pair_rd_data, rd_data_a, rd_data_b, wrap);
    end
  endtask

  task automatic test_wrap();
    idle();
    pair_op = 2'd1; pair_addr = 2'd0; pair_data = 16'hFFFF;
    tick();
    pair_op = 2'd2;
    tick();
    idle();
    pair_rd_addr = 2'd0;
    #1;
    tests_run++;
    if (pair_rd_data !== 16'h0000 || wrap !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_inc: got %h wrap=%b expected 0000 1", pair_rd_data, wrap);
    end
    pair_op = 2'd3;
    tick();
    idle();
    #1;
    tests_run++;
    if (pair_rd_data !== 16'hFFFF || wrap !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_dec: got %h wrap=%b expected ffff 1", pair_rd_data, wrap);
    end
    tick();
    tests_run++;
    if (wrap !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap_clear: got %b expected 0", wrap);
    end
  endtask

  task automatic test_collision();
    idle();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h77;
    tick();
    pair_op = 2'd1; pair_addr = 2'd1; pair_data = 16'hBEEF;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    tick();
    idle();
    rd_addr_a = 3'd2; rd_addr_b = 3'd3;
    #1;
    tests_run++;
    if (rd_data_a !== 8'hBE || rd_data_b !== 8'hEF) begin
      fails++;
      $display("[TB] FAIL collision: got %h %h expected be ef", rd_data_a, rd_data_b);
    end
    rd_addr_a = 3'd0;
    #1;
    tests_run++;
    if (rd_data_a !== 8'h77) begin
      fails++;
      $display("[TB] FAIL collision_other: got %h expected 77", rd_data_a);
    end
  endtask

  task automatic test_save_restore();
    idle();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(i + 1);
      tick();
    end
    idle();
    save = 1'b1;
    tick();
    idle();
    clr = 1'b1;
    tick();
    idle();
    rd_addr_a = 3'd0;
    #1;
    tests_run++;
    if (rd_data_a !== 8'h00 || shadow_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL clr_keeps_shadow: got %h valid=%b expected 00 1", rd_data_a, shadow_valid);
    end
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
    tick();
    idle();
    restore = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1;
      tests_run++;
      if (rd_data_a !== 8'(i + 1)) begin
        fails++;
        $display("[TB] FAIL restore[%0d]: got %h expected %h", i, rd_data_a, 8'(i + 1));
      end
    end
    tests_run++;
    if (shadow_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL restore_valid: got %b expected 0", shadow_valid);
    end
    restore = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h99;
    tick();
    idle();
    rd_addr_a = 3'd1; rd_addr_b = 3'd0;
    #1;
    tests_run++;
    if (rd_data_a !== 8'h99 || rd_data_b !== 8'h01) begin
      fails++;
      $display("[TB] FAIL restore_invalid: got %h %h expected 99 01", rd_data_a, rd_data_b);
    end
    save = 1'b1;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
    tick();
    idle();
    save = 1'b1; restore = 1'b1;
    tick();
    idle();
    rd_addr_a = 3'd0;
    #1;
    tests_run++;
    if (rd_data_a !== 8'h01 || shadow_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL save_restore_same: got %h valid=%b expected 01 0", rd_data_a, shadow_valid);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] old;
    idle();
    old = m_regs[6];
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h3C; rd_addr_a = 3'd6;
    #1;
    tests_run++;
`ifdef GB_REGFILE_BYPASS_EN
    if (rd_data_a !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected 3c", rd_data_a);
    end
`else
    if (rd_data_a !== old) begin
      fails++;
      $display("[TB] FAIL no_bypass_same_cycle: got %h expected %h", rd_data_a, old);
    end
`endif
    tick();
    idle();
    #1;
    tests_run++;
    if (rd_data_a !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL write_next_cycle: got %h expected 3c", rd_data_a);
    end
  endtask

  task automatic test_random();
    logic [7:0]  ea, eb;
    logic [15:0] ep;
    logic [2:0]  ra;
    for (int n = 0; n < 300; n++) begin
      reset     = 1'b0;
      clr       = ($urandom_range(0, 19) == 0);
      save      = ($urandom_range(0, 9) == 0);
      restore   = ($urandom_range(0, 9) == 0);
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom);
      pair_op   = 2'($urandom_range(0, 3));
      pair_addr = 2'($urandom_range(0, 3));
      pair_data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = 3'($urandom_range(0, 7));
      pair_rd_addr = 2'($urandom_range(0, 3));
      #1;
      model_step();
      ea = exp_view(rd_addr_a);
      eb = exp_view(rd_addr_b);
      ep = {exp_view({pair_rd_addr, 1'b0}), exp_view({pair_rd_addr, 1'b1})};
      tests_run++;
      if (rd_data_a !== ea || rd_data_b !== eb || pair_rd_data !== ep) begin
        fails++;
        $display("[TB] FAIL rand_read[%0d]: got %h %h %h expected %h %h %h",
                 n, rd_data_a, rd_data_b, pair_rd_data, ea, eb, ep);
      end
      tick();
      idle();
      ra = 3'($urandom_range(0, 7));
      rd_addr_a = ra;
      #1;
      tests_run++;
      if (wrap !== m_wrap || shadow_valid !== m_valid || rd_data_a !== m_regs[ra]) begin
        fails++;
        $display("[TB] FAIL rand_state[%0d]: got wrap=%b valid=%b r%0d=%h expected %b %b %h",
                 n, wrap, shadow_valid, ra, rd_data_a, m_wrap, m_valid, m_regs[ra]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_regs[i]   = 8'h00;
      m_shadow[i] = 8'h00;
    end
    m_valid = 1'b0;
    m_wrap  = 1'b0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; pair_rd_addr = 2'd0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_pair_inc();
    test_wrap();
    test_collision();
    test_save_restore();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
